algorithm_range: RTL

Stream source: on a start request it emits `count` consecutive integers beginning at `start` over a valid/ready stream, then pulses completion. It is the producing end of the stream interface that `algorithm_sum`-style consumers read. It sits between scalar control logic and stream-consuming algorithm blocks, so a range can be generated and reduced in hardware.

---
 rtl/algorithm_range_pkg.sv | 18 +
 rtl/algorithm_range_down_counter.sv | 45 ++++
 rtl/algorithm_range.sv | 138 +++++++++++++
 3 files changed

// File: rtl/algorithm_range_pkg.sv
// algorithm_range_pkg: shared definitions for the range stream source.
//   INT_N          default data width for start/count/stream beats
//   range_state_e  2-bit FSM encoding (RANGE_IDLE / RANGE_EMIT / RANGE_DONE)
//   true/false     single-bit constants
package algorithm_range_pkg;

    localparam int unsigned INT_N = 8;

    typedef enum logic [1:0] {
        RANGE_IDLE = 2'd0,
        RANGE_EMIT = 2'd1,
        RANGE_DONE = 2'd2
    } range_state_e;

    localparam logic true  = 1'b1;
    localparam logic false = 1'b0;

endpackage : algorithm_range_pkg

// File: rtl/algorithm_range_down_counter.sv
// algorithm_range_down_counter: N-bit loadable decrementer holding the
// number of beats still to be emitted.
// Ports:
//   clk, nrst      clock, async active-low reset
//   load_i         load load_value_i (has priority over dec_i)
//   load_value_i   value to load
//   dec_i          decrement by one
//   is_one_o       registered flag: remaining count equals 1
module algorithm_range_down_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         load_i,
    input  logic [W-1:0] load_value_i,
    input  logic         dec_i,
    output logic         is_one_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         is_one_q;

    // Next count; the flag is registered from it so it tracks cnt_q exactly.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_value_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q    <= '0;
            is_one_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            is_one_q <= (cnt_d == W'(1));
        end
    end

    assign is_one_o = is_one_q;

endmodule : algorithm_range_down_counter

// File: rtl/algorithm_range.sv
// algorithm_range: on a start request emits `count` consecutive values
// beginning at `start` over a valid/ready stream, then pulses out_valid.
// Optional build macro: ALGORITHM_RANGE_STEP_EN adds a `step` input latched
// with `start`; each transfer then adds `step` instead of 1.
// Ports:
//   clk, nrst               clock, async active-low reset
//   in_valid, start, count  start request (sampled only when idle)
//   step                    increment (only with ALGORITHM_RANGE_STEP_EN)
//   sOut, sOut_valid        stream beat; sOut is 0 when not valid
//   sOut_ready              consumer accepts the current beat
//   out_valid               one-cycle completion pulse
//   busy                    high while emitting or completing
module algorithm_range
    import algorithm_range_pkg::*;
#(
    parameter int unsigned N = INT_N
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         in_valid,
    input  logic [N-1:0] start,
    input  logic [N-1:0] count,
`ifdef ALGORITHM_RANGE_STEP_EN
    input  logic [N-1:0] step,
`endif
    input  logic         sOut_ready,
    output logic [N-1:0] sOut,
    output logic         sOut_valid,
    output logic         out_valid,
    output logic         busy
);

    range_state_e state_q, state_d;
    logic [N-1:0] value_q, value_d;
    logic [N-1:0] incr;
    logic         cnt_load, cnt_dec, cnt_is_one;
    logic         xfer;

    logic [N-1:0] sout_q, sout_d;
    logic         sout_valid_q, sout_valid_d;
    logic         out_valid_q, out_valid_d;
    logic         busy_q, busy_d;

`ifdef ALGORITHM_RANGE_STEP_EN
    logic [N-1:0] step_q, step_d;
    assign incr = step_q;
`else
    assign incr = N'(1);
`endif

    // sOut_valid_q is high exactly in EMIT, so this is the handshake.
    assign xfer = sout_valid_q & sOut_ready;

    algorithm_range_down_counter #(
        .W (N)
    ) u_remaining (
        .clk          (clk),
        .nrst         (nrst),
        .load_i       (cnt_load),
        .load_value_i (count),
        .dec_i        (cnt_dec),
        .is_one_o     (cnt_is_one)
    );

    // Next state, value register and registered output images.
    always_comb begin
        state_d  = state_q;
        value_d  = value_q;
        cnt_load = false;
        cnt_dec  = false;
`ifdef ALGORITHM_RANGE_STEP_EN
        step_d   = step_q;
`endif

        case (state_q)
            RANGE_IDLE: begin
                if (in_valid) begin
                    value_d  = start;
                    cnt_load = true;
`ifdef ALGORITHM_RANGE_STEP_EN
                    step_d   = step;
`endif
                    state_d  = (count != '0) ? RANGE_EMIT : RANGE_DONE;
                end
            end
            RANGE_EMIT: begin
                if (xfer) begin
                    value_d = value_q + incr;
                    cnt_dec = true;
                    if (cnt_is_one) begin
                        state_d = RANGE_DONE;
                    end
                end
            end
            RANGE_DONE: begin
                state_d = RANGE_IDLE;
            end
            default: begin
                state_d = RANGE_IDLE;
            end
        endcase

        sout_valid_d = (state_d == RANGE_EMIT);
        sout_d       = sout_valid_d ? value_d : '0;
        out_valid_d  = (state_d == RANGE_DONE);
        busy_d       = (state_d != RANGE_IDLE);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= RANGE_IDLE;
            value_q      <= '0;
            sout_q       <= '0;
            sout_valid_q <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef ALGORITHM_RANGE_STEP_EN
            step_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            value_q      <= value_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
`ifdef ALGORITHM_RANGE_STEP_EN
            step_q       <= step_d;
`endif
        end
    end

    assign sOut       = sout_q;
    assign sOut_valid = sout_valid_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;

endmodule : algorithm_range
